// File: rtl/calc_exec_unit.sv
// rtl/calc_exec_unit.sv - operand store and multi-cycle add/sub/mul/div engine for the calculator
// Define CALC_BCD_OUT_EN to convert results to packed BCD after the arithmetic phase.
module calc_exec_unit #(
   parameter int DW = 8
) (
   input  logic            CLK,
   input  logic            clear,
   input  logic [DW-1:0]   Din,
   input  logic            WE,
   input  logic            W1,
   input  logic [3:0]      MS,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] result,
   output logic            neg,
   output logic            err
);
   localparam int CW = $clog2(2*DW+1);

`ifdef CALC_BCD_OUT_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCD, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

   state_t            r_state, w_next;
   logic [DW-1:0]     r_a, r_b, r_wa, r_wb, r_mplier;
   logic [1:0]        r_op;
   logic [CW-1:0]     r_cnt, w_n;
   logic [2*DW-1:0]   r_acc, r_mcand, w_acc_nxt;
   logic [2*DW-1:0]   r_result;
   logic              r_neg, r_err, r_done, w_neg_nxt;
   logic              w_idle_like, w_accept, w_bad, w_last;
   logic [2*DW:0]     w_div_sh;
   logic [DW:0]       w_div_tr;

`ifdef CALC_BCD_OUT_EN
   logic [2*DW-1:0]   r_bin, r_bcd, w_bcd_adj, w_bin;
   logic              r_bneg, r_over;
`endif

   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept    = start && w_idle_like;
   assign w_bad       = (MS > 4'd3) || ((MS == 4'd3) && (r_b == '0));
   assign w_n         = r_op[1] ? CW'(DW) : CW'(1);
   assign w_last      = (r_cnt == w_n - CW'(1));

   assign busy   = (r_state == S_EXEC) ||
`ifdef CALC_BCD_OUT_EN
                   (r_state == S_BCD) ||
`endif
                   r_done;
   assign done   = r_done;
   assign result = r_result;
   assign neg    = r_neg;
   assign err    = r_err;

   // One iteration of the selected operation; DIV keeps {remainder, quotient} in r_acc
   always_comb begin
      w_acc_nxt = r_acc;
      w_neg_nxt = 1'b0;
      w_div_sh  = {r_acc, 1'b0};
      w_div_tr  = w_div_sh[2*DW:DW] - {1'b0, r_wb};
      case (r_op)
         2'd0: w_acc_nxt = {{DW{1'b0}}, r_wa} + {{DW{1'b0}}, r_wb};
         2'd1: begin
            if (r_wa >= r_wb) begin
               w_acc_nxt = {{DW{1'b0}}, r_wa - r_wb};
            end else begin
               w_acc_nxt = {{DW{1'b0}}, r_wb - r_wa};
               w_neg_nxt = 1'b1;
            end
         end
         2'd2: w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
         default: begin
            if (!w_div_tr[DW]) w_acc_nxt = {w_div_tr[DW-1:0], w_div_sh[DW-1:1], 1'b1};
            else               w_acc_nxt = w_div_sh[2*DW-1:0];
         end
      endcase
   end

`ifdef CALC_BCD_OUT_EN
   assign w_bin = (r_op == 2'd3) ? {{DW{1'b0}}, w_acc_nxt[DW-1:0]} : w_acc_nxt;

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 2*DW/4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end
`endif

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = w_bad ? S_DONE : S_EXEC;
`ifdef CALC_BCD_OUT_EN
         S_EXEC: if (w_last) w_next = S_BCD;
         S_BCD:  if (r_cnt == CW'(2*DW-1)) w_next = S_DONE;
`else
         S_EXEC: if (w_last) w_next = S_DONE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         r_a      <= '0;
         r_b      <= '0;
         r_wa     <= '0;
         r_wb     <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_result <= '0;
         r_neg    <= 1'b0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
`ifdef CALC_BCD_OUT_EN
         r_bin    <= '0;
         r_bcd    <= '0;
         r_bneg   <= 1'b0;
         r_over   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (WE && w_idle_like) begin
            if (W1) r_b <= Din;
            else    r_a <= Din;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept && w_bad) begin
                  r_result <= '0;
                  r_neg    <= 1'b0;
                  r_err    <= 1'b1;
                  r_done   <= 1'b1;
               end else if (w_accept) begin
                  r_op     <= MS[1:0];
                  r_wa     <= r_a;
                  r_wb     <= r_b;
                  r_cnt    <= '0;
                  r_acc    <= (MS[1:0] == 2'd3) ? {{DW{1'b0}}, r_a} : '0;
                  r_mcand  <= {{DW{1'b0}}, r_a};
                  r_mplier <= r_b;
               end
            end
            S_EXEC: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
`ifdef CALC_BCD_OUT_EN
                  r_bin  <= w_bin;
                  r_bcd  <= '0;
                  r_bneg <= w_neg_nxt;
                  r_over <= (w_bin > (2*DW)'(9999));
                  r_cnt  <= '0;
`else
                  r_result <= w_acc_nxt;
                  r_neg    <= w_neg_nxt;
                  r_err    <= 1'b0;
                  r_done   <= 1'b1;
`endif
               end
            end
`ifdef CALC_BCD_OUT_EN
            S_BCD: begin
               r_bcd <= {w_bcd_adj[2*DW-2:0], r_bin[2*DW-1]};
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(2*DW-1)) begin
                  r_result <= r_over ? {(2*DW/4){4'h9}} : {w_bcd_adj[2*DW-2:0], r_bin[2*DW-1]};
                  r_neg    <= r_bneg;
                  r_err    <= r_over;
                  r_done   <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_exec_unit.sv
// tb/tb_calc_exec_unit.sv - randomized self-checking bench for calc_exec_unit
// Reference model computes results with plain arithmetic; handles CALC_BCD_OUT_EN builds too.
module tb_calc_exec_unit;
   localparam int DW = 8;

   logic            CLK = 1'b0;
   logic            clear, WE, W1, start;
   logic [DW-1:0]   Din;
   logic [3:0]      MS;
   logic            busy, done, neg, err;
   logic [2*DW-1:0] result;
   logic            clk_run = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int ma = 0, mb = 0;
   int prev_res = 0;

   calc_exec_unit #(.DW(DW)) dut (
      .CLK(CLK), .clear(clear), .Din(Din), .WE(WE), .W1(W1), .MS(MS),
      .start(start), .busy(busy), .done(done), .result(result), .neg(neg), .err(err)
   );

   initial begin
      wait (clk_run);
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed != expected) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model(input int a, input int b, input int ms,
                        output int r, output int n, output int e, output int lat);
      r = 0; n = 0; e = 0;
      case (ms)
         0: r = a + b;
         1: if (a >= b) r = a - b; else begin r = b - a; n = 1; end
         2: r = a * b;
         3: if (b == 0) e = 1; else r = (a % b) * 256 + (a / b);
         default: e = 1;
      endcase
      lat = e ? 1 : (ms < 2 ? 2 : DW + 1);
`ifdef CALC_BCD_OUT_EN
      if (!e) begin
         int v;
         v = (ms == 3) ? (a / b) : r;
         if (v > 9999) begin r = 'h9999; e = 1; end
         else r = (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
         lat += 2 * DW;
      end
`endif
   endtask

   task automatic write_op(input logic sel, input int val);
      WE = 1'b1; W1 = sel; Din = val[DW-1:0];
      tick();
      WE = 1'b0;
      if (sel) mb = val; else ma = val;
   endtask

   task automatic run_op(input int ms, input string tag);
      int r, n, e, lat, cyc;
      model(ma, mb, ms, r, n, e, lat);
      start = 1'b1; MS = ms[3:0];
      tick();
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 60) begin
         check({tag, "_busy"}, int'(busy), 1);
         check({tag, "_held"}, int'(result), prev_res);
         tick();
         cyc++;
      end
      check({tag, "_lat"}, cyc, lat);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_busy_done"}, int'(busy), 1);
      check({tag, "_res"}, int'(result), r);
      check({tag, "_neg"}, int'(neg), n);
      check({tag, "_err"}, int'(err), e);
      prev_res = r;
   endtask

   initial begin
      clear = 1'b1; WE = 1'b0; W1 = 1'b0; Din = '0; MS = '0; start = 1'b0;
      #20;
      check("rst_result", int'(result), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_neg", int'(neg), 0);
      check("rst_err", int'(err), 0);
      clk_run = 1'b1;
      tick();
      clear = 1'b0;
      tick();

      write_op(1'b0, 200); write_op(1'b1, 100); run_op(0, "add");
      write_op(1'b0, 5);   write_op(1'b1, 12);  run_op(1, "sub_neg");
      write_op(1'b0, 255); write_op(1'b1, 255); run_op(2, "mul_max");
      write_op(1'b0, 200); write_op(1'b1, 7);   run_op(3, "div");
      write_op(1'b1, 0);   run_op(3, "div0");
      run_op(9, "bad_ms");
      // Back-to-back: start issued in the done cycle of the previous op
      write_op(1'b0, 40); write_op(1'b1, 3);
      run_op(2, "b2b_mul"); run_op(1, "b2b_sub"); run_op(3, "b2b_div");

      // WE coinciding with start: op uses old A, write still lands
      write_op(1'b0, 10); write_op(1'b1, 20);
      WE = 1'b1; W1 = 1'b0; Din = 8'd1;
      run_op(0, "we_start");
      WE = 1'b0; ma = 1;
      run_op(0, "we_after");

      for (int i = 0; i < 40; i++) begin
         int ms;
         write_op(1'b0, int'($urandom_range(0, 255)));
         write_op(1'b1, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)));
         ms = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
         run_op(ms, "rand");
      end

      // Start and WE pulsed while busy must be ignored
      write_op(1'b0, 3); write_op(1'b1, 5);
      start = 1'b1; MS = 4'd2;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; MS = 4'd0; WE = 1'b1; W1 = 1'b0; Din = 8'd9;
      tick();
      start = 1'b0; WE = 1'b0;
      begin
         int cyc = 4;
         while (!done && cyc < 60) begin tick(); cyc++; end
         check("busy_ign_lat", cyc, 9 + (DW == 8 ? 0 : 0)
`ifdef CALC_BCD_OUT_EN
               + 2 * DW
`endif
         );
         check("busy_ign_mul_err", int'(err), 0);
      end
      prev_res = int'(result);
      run_op(0, "ops_kept");

      // Clear in the middle of an operation
      start = 1'b1; MS = 4'd2;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2 clear = 1'b1;
      #1;
      check("clr_result", int'(result), 0);
      check("clr_busy", int'(busy), 0);
      check("clr_done", int'(done), 0);
      check("clr_neg", int'(neg), 0);
      check("clr_err", int'(err), 0);
      tick();
      clear = 1'b0;
      ma = 0; mb = 0; prev_res = 0;
      begin
         int seen = 0;
         for (int i = 0; i < 30; i++) begin
            if (done || busy) seen = 1;
            tick();
         end
         check("clr_no_done", seen, 0);
      end
      run_op(0, "clr_ops_zero");
      write_op(1'b0, 77); write_op(1'b1, 77); run_op(1, "sub_eq");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
